// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a length-prefixed byte stream into instruction memory as little-endian words
// Holds the CPU in reset (cpu_hold) while a load is in progress.
module instr_mem_loader #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wd,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           words_loaded
);
  localparam int MAX_WORDS = (2 ** ADDR_WIDTH) / 4;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR} state_t;
  state_t state, next;
  logic [15:0] len, word_idx, n_len;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q, asm_next;
  logic        xfer, idle_like;
  assign xfer      = in_valid && in_ready;
  assign idle_like = state inside {IDLE, DONE, ERR};
  assign n_len     = {in_data, len[7:0]};
  // lane 3 is never stored: it is merged straight into mem_wd on the last byte
  assign asm_next  = (asm_q & ~(24'hFF << {byte_idx, 3'b000})) | (24'(in_data) << {byte_idx, 3'b000});
  assign in_ready     = state inside {LEN_LO, LEN_HI, DATA};
  assign mem_we       = state == WRITE;
  assign busy         = state inside {LEN_LO, LEN_HI, DATA, WRITE};
  assign cpu_hold     = busy;
  assign done         = state == DONE;
  assign err          = state == ERR;
  assign words_loaded = word_idx;
  always_comb begin
    next = state;
    unique case (state)
      IDLE, DONE, ERR: next = start ? LEN_LO : state;
      LEN_LO: next = xfer ? LEN_HI : LEN_LO;
      LEN_HI: next = !xfer ? LEN_HI : n_len == 16'd0 ? DONE :
                     {1'b0, n_len} > 17'(MAX_WORDS) ? ERR : DATA;
      DATA:   next = (xfer && byte_idx == 2'd3) ? WRITE : DATA;
      WRITE:  next = (word_idx + 16'd1 == len) ? DONE : DATA;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      asm_q    <= '0;
      mem_addr <= '0;
      mem_wd   <= '0;
    end else begin
      if (start && idle_like) begin
        len      <= '0;
        word_idx <= '0;
        byte_idx <= '0;
      end
      if (xfer && state == LEN_LO) len[7:0] <= in_data;
      if (xfer && state == LEN_HI) begin
        len[15:8] <= in_data;
        word_idx  <= '0;
        byte_idx  <= '0;
      end
      if (xfer && state == DATA) begin
        byte_idx <= byte_idx + 2'd1;
        asm_q    <= asm_next;
        if (byte_idx == 2'd3) begin
          mem_wd   <= WIDTH'({in_data, asm_q});
          mem_addr <= ADDR_WIDTH'({word_idx, 2'b00});
        end
      end
      if (state == WRITE) begin
        word_idx <= word_idx + 16'd1;
        byte_idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: scoreboard bench for instr_mem_loader
// Expected (addr, data) pairs are queued as bytes are sent and popped on each mem_we.
module tb_instr_mem_loader;
  logic        clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, mem_we, busy, cpu_hold, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wd;
  logic [15:0] words_loaded;
  int checks = 0, passes = 0;
  int we_cnt = 0, busy_cnt = 0;
  logic [7:0]  last_addr = 0;
  logic [39:0] exp_q[$];
  logic [39:0] e;
  logic [31:0] prog[64];

  instr_mem_loader #(.WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (mem_we) begin
      we_cnt++;
      last_addr = mem_addr;
      checks++;
      if (exp_q.size() == 0) $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wd);
      else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wd} !== e)
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h", mem_addr, mem_wd, e[39:32], e[31:0]);
        else passes++;
      end
      checks++;
      if (in_ready !== 1'b0) $display("FAIL ready_in_write got %b want 0", in_ready);
      else passes++;
    end
  end

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1;
    in_data = b;
    @(negedge clk);
    while (!in_ready && t < 50) begin t++; @(negedge clk); end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout byte=%h in_ready=%b want 1", b, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_end();
    int t = 0;
    @(negedge clk);
    while (!done && !err && t < 1000) begin t++; @(negedge clk); end
    if (!done && !err) begin
      checks++;
      $display("FAIL wait_timeout done=%b err=%b want one set", done, err);
    end
  endtask

  task automatic load_frame(input int n, input int start_at);
    int k = 0;
    pulse_start();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int w = 0; w < n; w++)
      for (int b = 0; b < 4; b++) begin
        if (b == 3) exp_q.push_back({8'(w * 4), prog[w]});
        if (k == start_at) start = 1;
        send_byte(prog[w][8*b +: 8]);
        start = 0;
        k++;
      end
  endtask

  task automatic test_reset();
    rst = 1; #1; rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wd, busy, cpu_hold, done, err, words_loaded} !== '0)
      $display("FAIL reset_outputs got %h want 0",
               {in_ready, mem_we, mem_addr, mem_wd, busy, cpu_hold, done, err, words_loaded});
    else passes++;
    @(posedge clk); #1; rst = 1;
  endtask

  task automatic test_basic();
    prog[0] = 32'h00A00513;
    prog[1] = 32'h00100593;
    we_cnt = 0; busy_cnt = 0;
    load_frame(2, -1);
    wait_end();
    checks++;
    if ({done, err} !== 2'b10) $display("FAIL basic_done got done=%b err=%b want 1 0", done, err);
    else passes++;
    checks++;
    if (words_loaded !== 16'd2) $display("FAIL basic_words got %0d want 2", words_loaded);
    else passes++;
    checks++;
    if (we_cnt !== 2) $display("FAIL basic_we_count got %0d want 2", we_cnt);
    else passes++;
    checks++;
    if (busy_cnt !== 12) $display("FAIL basic_cycles got %0d want 12", busy_cnt);
    else passes++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL basic_pending got %0d want 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_zero_len();
    we_cnt = 0;
    load_frame(0, -1);
    wait_end();
    checks++;
    if ({done, err, we_cnt == 0, words_loaded} !== {3'b101, 16'd0})
      $display("FAIL zero_len got done=%b err=%b we=%0d words=%0d want 1 0 0 0", done, err, we_cnt, words_loaded);
    else passes++;
  endtask

  task automatic test_overflow();
    we_cnt = 0;
    pulse_start();
    send_byte(8'h41);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if ({err, done, busy} !== 3'b100 || we_cnt != 0)
      $display("FAIL overflow got err=%b done=%b busy=%b we=%0d want 1 0 0 0", err, done, busy, we_cnt);
    else passes++;
    prog[0] = 32'hDEADBEEF;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    checks++;
    if ({err, busy} !== 2'b01) $display("FAIL overflow_restart got err=%b busy=%b want 0 1", err, busy);
    else passes++;
    send_byte(8'h01);
    send_byte(8'h00);
    exp_q.push_back({8'h00, prog[0]});
    for (int b = 0; b < 4; b++) send_byte(prog[0][8*b +: 8]);
    wait_end();
    checks++;
    if ({done, err} !== 2'b10 || we_cnt != 1)
      $display("FAIL overflow_reload got done=%b err=%b we=%0d want 1 0 1", done, err, we_cnt);
    else passes++;
  endtask

  task automatic test_stall();
    logic [6:0]  pat = 7'b1011001;
    logic [31:0] word = 32'h44332211;
    int k = 0;
    we_cnt = 0;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    exp_q.push_back({8'h00, word});
    for (int i = 6; i >= 0; i--) begin
      in_valid = pat[i];
      in_data = pat[i] ? word[8*k +: 8] : 8'hEE;
      @(posedge clk); #1;
      if (pat[i]) k++;
    end
    in_valid = 0;
    wait_end();
    checks++;
    if ({done, we_cnt == 1, words_loaded} !== {2'b11, 16'd1})
      $display("FAIL stall got done=%b we=%0d words=%0d want 1 1 1", done, we_cnt, words_loaded);
    else passes++;
  endtask

  task automatic test_reset_midload();
    int wc;
    prog[0] = 32'hCAFEF00D;
    we_cnt = 0;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    exp_q.push_back({8'h00, prog[0]});
    for (int b = 0; b < 4; b++) send_byte(prog[0][8*b +: 8]);
    send_byte(8'h55);
    send_byte(8'h66);
    #2 rst = 0;
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wd, busy, cpu_hold, done, err, words_loaded} !== '0)
      $display("FAIL async_reset got %h want 0",
               {in_ready, mem_we, mem_addr, mem_wd, busy, cpu_hold, done, err, words_loaded});
    else passes++;
    wc = we_cnt;
    repeat (3) @(negedge clk);
    checks++;
    if (we_cnt != 1 || wc != 1) $display("FAIL reset_no_write got %0d want 1", we_cnt);
    else passes++;
    exp_q.delete();
    @(posedge clk); #1; rst = 1;
    prog[0] = 32'h12345678;
    we_cnt = 0;
    load_frame(1, -1);
    wait_end();
    checks++;
    if ({done, we_cnt == 1, exp_q.size() == 0} !== 3'b111)
      $display("FAIL reset_reload got done=%b we=%0d pending=%0d want 1 1 0", done, we_cnt, exp_q.size());
    else passes++;
  endtask

  task automatic test_full_with_start();
    for (int i = 0; i < 64; i++) prog[i] = $urandom;
    we_cnt = 0;
    load_frame(64, 9);
    wait_end();
    checks++;
    if ({done, err} !== 2'b10) $display("FAIL full_done got done=%b err=%b want 1 0", done, err);
    else passes++;
    checks++;
    if (we_cnt != 64 || words_loaded !== 16'd64)
      $display("FAIL full_count got we=%0d words=%0d want 64 64", we_cnt, words_loaded);
    else passes++;
    checks++;
    if (last_addr !== 8'hFC) $display("FAIL full_last_addr got %h want fc", last_addr);
    else passes++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL full_pending got %0d want 0", exp_q.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_stall();
    test_reset_midload();
    test_full_with_start();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
